// File: rtl/spi_over_jtag_xfer_if.sv
// rtl/spi_over_jtag_xfer_if.sv - SPI bus between the JTAG transfer master and its slaves
interface spi_over_jtag_xfer_if #(
  parameter int CS_NUM = 2
);
  logic              spi_clk;
  logic [CS_NUM-1:0] spi_csn;
  logic              spi_si;
  logic              spi_so;

  modport master (output spi_clk, output spi_csn, output spi_si, input spi_so);
  modport slave  (input spi_clk, input spi_csn, input spi_si, output spi_so);
endinterface

// File: rtl/spi_over_jtag_xfer.sv
// rtl/spi_over_jtag_xfer.sv - length-framed SPI master driven by a virtual-JTAG DR scan
module spi_over_jtag_xfer #(
  parameter int IR_WIDTH = 9,
  parameter int CS_NUM   = 2,
  parameter int LEN_MODE = 1,
  parameter int LEN_W    = 16
) (
  input  logic                tck,
  input  logic                rst_n,
  input  logic                tdi,
  output logic                tdo,
  input  logic [IR_WIDTH-1:0] ir_in,
  input  logic                vs_cdr,
  input  logic                vs_sdr,
  input  logic                vs_uir,
  spi_over_jtag_xfer_if.master spi,
  output logic                busy,
  output logic                err
);

  localparam int SEL_W  = IR_WIDTH - 8;
  localparam int HDR_CW = $clog2(LEN_W + 1);
  localparam logic [SEL_W:0]      CS_LIM   = (SEL_W + 1)'(CS_NUM);
  localparam logic [HDR_CW-1:0]   HDR_LAST = HDR_CW'(LEN_W - 1);

  typedef enum logic [1:0] {IDLE, HDR, XFER, TAIL} state_t;

  // negedge domain
  logic             sdr_dly_q, cdr_dly_q, err_q, err_d;
  logic             xfer_en_q, xfer_en_d, spi_si_q, spi_si_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  // posedge domain
  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, len_shift;
  logic [LEN_W-1:0]  stat_sr_q, stat_sr_d, rem_q, rem_d, done_cnt_q, done_cnt_d;
  logic [HDR_CW-1:0] hdr_cnt_q, hdr_cnt_d;
  logic [7:0]        dsr_q, dsr_d;
  logic [SEL_W-1:0]  act_sel_q, act_sel_d;
  logic              tdi_q;

  always_comb begin
    cmd_d = cmd_q;
    sel_d = sel_q;
    err_d = err_q;
    if (vs_uir) begin
      cmd_d = ir_in[7:0];
      sel_d = ir_in[IR_WIDTH-1:8];
      err_d = ({1'b0, ir_in[IR_WIDTH-1:8]} >= CS_LIM);
    end
    xfer_en_d = (state_q == XFER) && vs_sdr && !err_q;
    spi_si_d  = (xfer_en_q || xfer_en_d) ? dsr_q[0] : spi_si_q;
  end

  always_ff @(negedge tck or negedge rst_n) begin
    if (!rst_n) begin
      sdr_dly_q <= 1'b0;
      cdr_dly_q <= 1'b0;
      cmd_q     <= '0;
      sel_q     <= '0;
      err_q     <= 1'b0;
      xfer_en_q <= 1'b0;
      spi_si_q  <= 1'b0;
    end else begin
      sdr_dly_q <= vs_sdr;
      cdr_dly_q <= vs_cdr;
      cmd_q     <= cmd_d;
      sel_q     <= sel_d;
      err_q     <= err_d;
      xfer_en_q <= xfer_en_d;
      spi_si_q  <= spi_si_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    stat_sr_d  = stat_sr_q;
    rem_d      = rem_q;
    done_cnt_d = done_cnt_q;
    hdr_cnt_d  = hdr_cnt_q;
    dsr_d      = dsr_q;
    act_sel_d  = act_sel_q;
    len_shift  = {tdi, len_q[LEN_W-1:1]};
    if (cdr_dly_q) begin
      stat_sr_d  = done_cnt_q;
      dsr_d      = cmd_q;
      done_cnt_d = '0;
      hdr_cnt_d  = '0;
      len_d      = '0;
      rem_d      = '0;
      act_sel_d  = sel_q;
      state_d    = (LEN_MODE != 0) ? HDR : XFER;
    end else if (!sdr_dly_q) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        HDR: begin
          len_d     = len_shift;
          stat_sr_d = stat_sr_q >> 1;
          hdr_cnt_d = hdr_cnt_q + HDR_CW'(1);
          if (hdr_cnt_q == HDR_LAST) begin
            rem_d   = len_shift;
            state_d = (len_shift != '0 && !err_q) ? XFER : TAIL;
          end
        end
        XFER: begin
          if (xfer_en_q) begin
            dsr_d = {tdi, dsr_q[7:1]};
            if (done_cnt_q != '1) done_cnt_d = done_cnt_q + LEN_W'(1);
            if (LEN_MODE != 0) begin
              rem_d = rem_q - LEN_W'(1);
              if (rem_q == LEN_W'(1)) state_d = TAIL;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      stat_sr_q  <= '0;
      rem_q      <= '0;
      done_cnt_q <= '0;
      hdr_cnt_q  <= '0;
      dsr_q      <= '0;
      act_sel_q  <= '0;
      tdi_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      stat_sr_q  <= stat_sr_d;
      rem_q      <= rem_d;
      done_cnt_q <= done_cnt_d;
      hdr_cnt_q  <= hdr_cnt_d;
      dsr_q      <= dsr_d;
      act_sel_q  <= act_sel_d;
      tdi_q      <= tdi;
    end
  end

  // xfer_en only moves on negedge, so the gated clock cannot glitch high
  assign spi.spi_clk = xfer_en_q & tck;
  assign spi.spi_si  = spi_si_q;
  assign busy        = xfer_en_q;
  assign err         = err_q;

  always_comb begin
    spi.spi_csn = '1;
    if (!err_q) begin
      for (int i = 0; i < CS_NUM; i++) begin
        if (act_sel_q == SEL_W'(i)) spi.spi_csn[i] = ~xfer_en_q;
      end
    end
  end

  always_comb begin
    if (state_q == HDR)  tdo = stat_sr_q[0];
    else if (xfer_en_q)  tdo = spi.spi_so;
    else                 tdo = tdi_q;
  end

endmodule
